// File: rtl/cfu_arb2_l2.sv
// cfu_arb2_l2: shares one CFU-L2 streaming target between two CFU-L2 initiators.
// Requests are arbitrated combinationally and each winner index is queued in
// an in-order tag FIFO that routes target responses back to their issuer.
// Build option: define CFU_ARB2_FIXED_PRIO_EN for fixed priority (i0 wins ties);
// left undefined the arbiter is round-robin.
module cfu_arb2_l2 #(
  parameter int CFU_N_CFUS    = 1,
  parameter int CFU_N_STATES  = 1,
  parameter int CFU_FUNC_ID_W = 10,
  parameter int CFU_INSN_W    = 32,
  parameter int CFU_DATA_W    = 32,
  parameter int DEPTH         = 4,
  localparam int CFU_ID_W     = (CFU_N_CFUS > 1) ? $clog2(CFU_N_CFUS) : 1,
  localparam int STATE_W      = (CFU_N_STATES > 1) ? $clog2(CFU_N_STATES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // initiator 0
  input  logic                     i0_req_valid,
  output logic                     i0_req_ready,
  input  logic [CFU_ID_W-1:0]      i0_req_cfu,
  input  logic [STATE_W-1:0]       i0_req_state,
  input  logic [CFU_FUNC_ID_W-1:0] i0_req_func,
  input  logic [CFU_INSN_W-1:0]    i0_req_insn,
  input  logic [CFU_DATA_W-1:0]    i0_req_data0,
  input  logic [CFU_DATA_W-1:0]    i0_req_data1,
  output logic                     i0_resp_valid,
  input  logic                     i0_resp_ready,
  output logic [3:0]               i0_resp_status,
  output logic [CFU_DATA_W-1:0]    i0_resp_data,
  // initiator 1
  input  logic                     i1_req_valid,
  output logic                     i1_req_ready,
  input  logic [CFU_ID_W-1:0]      i1_req_cfu,
  input  logic [STATE_W-1:0]       i1_req_state,
  input  logic [CFU_FUNC_ID_W-1:0] i1_req_func,
  input  logic [CFU_INSN_W-1:0]    i1_req_insn,
  input  logic [CFU_DATA_W-1:0]    i1_req_data0,
  input  logic [CFU_DATA_W-1:0]    i1_req_data1,
  output logic                     i1_resp_valid,
  input  logic                     i1_resp_ready,
  output logic [3:0]               i1_resp_status,
  output logic [CFU_DATA_W-1:0]    i1_resp_data,
  // target
  output logic                     t_req_valid,
  input  logic                     t_req_ready,
  output logic [CFU_ID_W-1:0]      t_req_cfu,
  output logic [STATE_W-1:0]       t_req_state,
  output logic [CFU_FUNC_ID_W-1:0] t_req_func,
  output logic [CFU_INSN_W-1:0]    t_req_insn,
  output logic [CFU_DATA_W-1:0]    t_req_data0,
  output logic [CFU_DATA_W-1:0]    t_req_data1,
  input  logic                     t_resp_valid,
  output logic                     t_resp_ready,
  input  logic [3:0]               t_resp_status,
  input  logic [CFU_DATA_W-1:0]    t_resp_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             lock;
  logic             lock_sel;
  logic             pick;
  logic             sel;
  logic             full;
  logic             empty;
  logic             head;
  logic             accept;
  logic             req_fire;
  logic             resp_fire;
  logic [DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

`ifdef CFU_ARB2_FIXED_PRIO_EN
  // i0 wins whenever it is valid
  assign pick = !i0_req_valid && i1_req_valid;
`else
  logic last;

  // on a tie choose the initiator that did not win last; otherwise the valid one
  assign pick = (i0_req_valid && i1_req_valid) ? !last : i1_req_valid;

  // round-robin history, updated on every accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (req_fire) begin
      last <= sel;
    end
  end
`endif

  // a stalled request keeps its winner so the target payload cannot change
  assign sel = lock ? lock_sel : pick;

  assign accept       = !rst && t_req_ready && !full;
  assign t_req_valid  = !rst && !full && (sel ? i1_req_valid : i0_req_valid);
  assign i0_req_ready = accept && !sel;
  assign i1_req_ready = accept && sel;
  assign req_fire     = t_req_valid && t_req_ready;

  assign t_req_cfu   = sel ? i1_req_cfu   : i0_req_cfu;
  assign t_req_state = sel ? i1_req_state : i0_req_state;
  assign t_req_func  = sel ? i1_req_func  : i0_req_func;
  assign t_req_insn  = sel ? i1_req_insn  : i0_req_insn;
  assign t_req_data0 = sel ? i1_req_data0 : i0_req_data0;
  assign t_req_data1 = sel ? i1_req_data1 : i0_req_data1;

  // responses go to the initiator recorded at the FIFO head
  assign i0_resp_valid  = !rst && t_resp_valid && !empty && !head;
  assign i1_resp_valid  = !rst && t_resp_valid && !empty && head;
  assign t_resp_ready   = !rst && !empty && (head ? i1_resp_ready : i0_resp_ready);
  assign resp_fire      = t_resp_valid && t_resp_ready;
  assign i0_resp_status = t_resp_status;
  assign i1_resp_status = t_resp_status;
  assign i0_resp_data   = t_resp_data;
  assign i1_resp_data   = t_resp_data;

  // hold the winner while the target back-pressures, release on fire
  always_ff @(posedge clk) begin
    if (rst) begin
      lock     <= 1'b0;
      lock_sel <= 1'b0;
    end else if (req_fire) begin
      lock     <= 1'b0;
    end else if (t_req_valid && !t_req_ready) begin
      lock     <= 1'b1;
      lock_sel <= sel;
    end
  end

  // in-order tag FIFO: push winner on request fire, pop on response fire
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (req_fire) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (resp_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (req_fire && !resp_fire) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (resp_fire && !req_fire) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

  // a target response with no outstanding request breaks the ordering contract
  a_resp_needs_tag: assert property (@(posedge clk) disable iff (rst) !(t_resp_valid && empty));

endmodule

// File: tb/tb_cfu_arb2_l2.sv
// tb_cfu_arb2_l2: directed scoreboard bench for cfu_arb2_l2 with a small target model.
// Honours CFU_ARB2_FIXED_PRIO_EN for the arbitration-order expectations.
module tb_cfu_arb2_l2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i0_req_valid, i0_req_ready, i1_req_valid, i1_req_ready;
  logic [0:0]  i0_req_cfu, i1_req_cfu, t_req_cfu;
  logic [0:0]  i0_req_state, i1_req_state, t_req_state;
  logic [9:0]  i0_req_func, i1_req_func, t_req_func;
  logic [31:0] i0_req_insn, i1_req_insn, t_req_insn;
  logic [31:0] i0_req_data0, i0_req_data1, i1_req_data0, i1_req_data1;
  logic [31:0] t_req_data0, t_req_data1;
  logic        i0_resp_valid, i0_resp_ready, i1_resp_valid, i1_resp_ready;
  logic [3:0]  i0_resp_status, i1_resp_status, t_resp_status;
  logic [31:0] i0_resp_data, i1_resp_data, t_resp_data;
  logic        t_req_valid, t_req_ready, t_resp_valid, t_resp_ready;

  cfu_arb2_l2 #(.CFU_N_CFUS(1), .CFU_N_STATES(1), .CFU_FUNC_ID_W(10),
                .CFU_INSN_W(32), .CFU_DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i0_req_valid(i0_req_valid), .i0_req_ready(i0_req_ready), .i0_req_cfu(i0_req_cfu),
    .i0_req_state(i0_req_state), .i0_req_func(i0_req_func), .i0_req_insn(i0_req_insn),
    .i0_req_data0(i0_req_data0), .i0_req_data1(i0_req_data1),
    .i0_resp_valid(i0_resp_valid), .i0_resp_ready(i0_resp_ready),
    .i0_resp_status(i0_resp_status), .i0_resp_data(i0_resp_data),
    .i1_req_valid(i1_req_valid), .i1_req_ready(i1_req_ready), .i1_req_cfu(i1_req_cfu),
    .i1_req_state(i1_req_state), .i1_req_func(i1_req_func), .i1_req_insn(i1_req_insn),
    .i1_req_data0(i1_req_data0), .i1_req_data1(i1_req_data1),
    .i1_resp_valid(i1_resp_valid), .i1_resp_ready(i1_resp_ready),
    .i1_resp_status(i1_resp_status), .i1_resp_data(i1_resp_data),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_cfu(t_req_cfu),
    .t_req_state(t_req_state), .t_req_func(t_req_func), .t_req_insn(t_req_insn),
    .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
    .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
    .t_resp_status(t_resp_status), .t_resp_data(t_resp_data)
  );

  int          total = 0;
  int          bad = 0;
  int          k0, k1, n_f0, n_f1, n_r0, n_r1;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  logic [31:0] tgt_q[$];
  logic        resp_en, chk_order, alt, exp_id;

  function automatic logic [31:0] resp_fn(input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive payloads and the target response, then let combinational paths settle
  task automatic settle();
    i0_req_data0 = {16'h0000, 16'(k0)};
    i0_req_data1 = 32'h1111_0000 + 32'(k0);
    i1_req_data0 = {16'h8000, 16'(k1)};
    i1_req_data1 = 32'h2222_0000 + 32'(k1);
    t_resp_valid = resp_en && (tgt_q.size() > 0);
    t_resp_data  = t_resp_valid ? tgt_q[0] : 32'h0;
    t_resp_status = t_resp_data[3:0];
    #1;
  endtask

  // record handshakes into the scoreboard, then move to just after the next edge
  task automatic advance();
    logic f0, f1, tf, r0, r1, trf;
    f0  = i0_req_valid && i0_req_ready;
    f1  = i1_req_valid && i1_req_ready;
    tf  = t_req_valid && t_req_ready;
    r0  = i0_resp_valid && i0_resp_ready;
    r1  = i1_resp_valid && i1_resp_ready;
    trf = t_resp_valid && t_resp_ready;
    if (chk_order && tf) begin
`ifdef CFU_ARB2_FIXED_PRIO_EN
      exp_id = !i0_req_valid;
`else
      exp_id = alt;
      alt = !alt;
`endif
      chk("order", 32'(t_req_data0[31]), 32'(exp_id));
    end
    if (tf) tgt_q.push_back(resp_fn(t_req_data0, t_req_data1));
    if (f0) begin exp0.push_back(resp_fn(i0_req_data0, i0_req_data1)); k0++; n_f0++; end
    if (f1) begin exp1.push_back(resp_fn(i1_req_data0, i1_req_data1)); k1++; n_f1++; end
    if (r0) begin
      n_r0++;
      if (exp0.size() == 0) chk("resp0_unexpected", 32'd1, 32'd0);
      else chk("resp0_data", i0_resp_data, exp0.pop_front());
    end
    if (r1) begin
      n_r1++;
      if (exp1.size() == 0) chk("resp1_unexpected", 32'd1, 32'd0);
      else chk("resp1_data", i1_resp_data, exp1.pop_front());
    end
    if (trf) void'(tgt_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin settle(); advance(); end
  endtask

  initial begin
    rst = 1'b1;
    i0_req_valid = 1'b0; i1_req_valid = 1'b0;
    i0_req_cfu = 1'b0; i1_req_cfu = 1'b1;
    i0_req_state = 1'b0; i1_req_state = 1'b1;
    i0_req_func = 10'h00A; i1_req_func = 10'h01B;
    i0_req_insn = 32'hA000_0001; i1_req_insn = 32'hB000_0002;
    i0_resp_ready = 1'b1; i1_resp_ready = 1'b1;
    t_req_ready = 1'b1; resp_en = 1'b1; chk_order = 1'b0; alt = 1'b0; exp_id = 1'b0;
    k0 = 0; k1 = 0; n_f0 = 0; n_f1 = 0; n_r0 = 0; n_r1 = 0;
    @(posedge clk); #1;

    // reset state: everything quiet even with both initiators requesting
    i0_req_valid = 1'b1; i1_req_valid = 1'b1;
    settle();
    chk("rst_t_req_valid", 32'(t_req_valid), 32'd0);
    chk("rst_i0_req_ready", 32'(i0_req_ready), 32'd0);
    chk("rst_i1_req_ready", 32'(i1_req_ready), 32'd0);
    chk("rst_t_resp_ready", 32'(t_resp_ready), 32'd0);
    advance();
    rst = 1'b0;

    // both initiators stream 8 requests each, target answers after one cycle
    chk_order = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (k0 == 8 && k1 == 8 && exp0.size() == 0 && exp1.size() == 0) break;
      i0_req_valid = (k0 < 8);
      i1_req_valid = (k1 < 8);
      settle();
      advance();
    end
    chk_order = 1'b0;
    i0_req_valid = 1'b0; i1_req_valid = 1'b0;
    chk("t1_resp0_count", 32'(n_r0), 32'd8);
    chk("t1_resp1_count", 32'(n_r1), 32'd8);

    // lock: one i0 fire leaves i1 preferred, then a 3-cycle stall with i1 arriving
    i0_req_valid = 1'b1;
    settle();
    chk("t2_pre_ready0", 32'(i0_req_ready), 32'd1);
    advance();
    i0_req_valid = 1'b0;
    idle(3);
    t_req_ready = 1'b0;
    i0_req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i1_req_valid = (c >= 1);
      settle();
      chk("t2_stall_valid", 32'(t_req_valid), 32'd1);
      chk("t2_stall_data0", t_req_data0, {16'h0000, 16'(k0)});
      chk("t2_stall_func", 32'(t_req_func), 32'h00A);
      chk("t2_stall_insn", t_req_insn, 32'hA000_0001);
      chk("t2_stall_ready0", 32'(i0_req_ready), 32'd0);
      chk("t2_stall_ready1", 32'(i1_req_ready), 32'd0);
      advance();
    end
    t_req_ready = 1'b1;
    settle();
    chk("t2_fire_ready0", 32'(i0_req_ready), 32'd1);
    chk("t2_fire_data0", t_req_data0, {16'h0000, 16'(k0)});
    advance();
    i0_req_valid = 1'b0;
    settle();
    chk("t2_next_ready1", 32'(i1_req_ready), 32'd1);
    chk("t2_next_data0", t_req_data0, {16'h8000, 16'(k1)});
    chk("t2_next_cfu", 32'(t_req_cfu), 32'd1);
    chk("t2_next_state", 32'(t_req_state), 32'd1);
    advance();
    i1_req_valid = 1'b0;
    idle(4);

    // target silent: four fires fill the tag FIFO
    resp_en = 1'b0;
    i0_req_valid = 1'b1; i1_req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t3_fill_fire", 32'(t_req_valid && t_req_ready), 32'd1);
      advance();
    end
    settle();
    chk("t3_full_valid", 32'(t_req_valid), 32'd0);
    chk("t3_full_ready0", 32'(i0_req_ready), 32'd0);
    chk("t3_full_ready1", 32'(i1_req_ready), 32'd0);
    advance();
    resp_en = 1'b1;
    settle();
    chk("t3_pop_tready", 32'(t_resp_ready), 32'd1);
    chk("t3_pop_no_push", 32'(t_req_valid), 32'd0);
    advance();
    resp_en = 1'b0;
    settle();
    chk("t3_push_after", 32'(t_req_valid && t_req_ready), 32'd1);
    advance();
    i0_req_valid = 1'b0; i1_req_valid = 1'b0;
    resp_en = 1'b1;
    idle(8);
    chk("t3_drain0", 32'(exp0.size()), 32'd0);
    chk("t3_drain1", 32'(exp1.size()), 32'd0);

    // i1 response at the head while i1 is not ready
    i1_resp_ready = 1'b0;
    i1_req_valid = 1'b1;
    settle();
    advance();
    i1_req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("t4_tready_hold", 32'(t_resp_ready), 32'd0);
      chk("t4_resp0_valid", 32'(i0_resp_valid), 32'd0);
      chk("t4_resp1_valid", 32'(i1_resp_valid), 32'd1);
      chk("t4_status_fan", 32'(i1_resp_status), 32'(t_resp_status));
      chk("t4_status_fan0", 32'(i0_resp_status), 32'(t_resp_status));
      advance();
    end
    i1_resp_ready = 1'b1;
    n_r1 = 0;
    settle();
    chk("t4_tready_go", 32'(t_resp_ready), 32'd1);
    advance();
    chk("t4_delivered", 32'(n_r1), 32'd1);

    // reset with three outstanding requests
    resp_en = 1'b0;
    i0_req_valid = 1'b1;
    idle(3);
    i0_req_valid = 1'b0;
    rst = 1'b1;
    i0_req_valid = 1'b1; i1_req_valid = 1'b1;
    settle();
    chk("t5_rst_valid", 32'(t_req_valid), 32'd0);
    chk("t5_rst_ready0", 32'(i0_req_ready), 32'd0);
    chk("t5_rst_ready1", 32'(i1_req_ready), 32'd0);
    advance();
    tgt_q.delete(); exp0.delete(); exp1.delete();
    rst = 1'b0;
    resp_en = 1'b1;
    settle();
    chk("t5_empty_tready", 32'(t_resp_ready), 32'd0);
    chk("t5_win_ready0", 32'(i0_req_ready), 32'd1);
    chk("t5_win_ready1", 32'(i1_req_ready), 32'd0);
    advance();

    // six cycles with both initiators valid
    n_f0 = 0; n_f1 = 0;
    idle(6);
    i0_req_valid = 1'b0; i1_req_valid = 1'b0;
`ifdef CFU_ARB2_FIXED_PRIO_EN
    chk("t6_i0_fires", 32'(n_f0), 32'd6);
    chk("t6_i1_fires", 32'(n_f1), 32'd0);
`else
    chk("t6_i0_fires", 32'(n_f0), 32'd3);
    chk("t6_i1_fires", 32'(n_f1), 32'd3);
`endif
    idle(6);
    chk("end_exp0_empty", 32'(exp0.size()), 32'd0);
    chk("end_exp1_empty", 32'(exp1.size()), 32'd0);
    chk("end_tgt_empty", 32'(tgt_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
